psum_drain_ctrl: RTL

PSUM_DRAIN_CTRL -- requirements
Module: psum_drain_ctrl

---
 rtl/psum_drain_ctrl_pkg.sv | 21 ++
 rtl/psum_drain_ctrl_slot_bank.sv | 59 +++++
 rtl/psum_drain_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/psum_drain_ctrl_pkg.sv
// Shared data-format package for the partial-sum drain controller: default
// geometry, the FSM state type and a helper for counter sizing.
package psum_drain_ctrl_pkg;

    localparam int unsigned DEF_NUM_SLOTS = 9;
    localparam int unsigned DEF_NUM_TERMS = 5;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ADDR_W    = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } drain_state_e;

    // Bits needed to count 0..terms inclusive.
    function automatic int unsigned cnt_width(input int unsigned terms);
        return (terms < 1) ? 1 : $clog2(terms + 1);
    endfunction

endpackage

// File: rtl/psum_drain_ctrl_slot_bank.sv
// Per-slot term counters and modular accumulators with one write port and
// one read port addressed by the drain pointer.
module psum_slot_bank
    import psum_drain_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned NUM_TERMS = DEF_NUM_TERMS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned CNT_W     = cnt_width(NUM_TERMS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_slot_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ok_o,
    input  logic [ADDR_W-1:0] rd_ptr_i,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [DATA_W-1:0] rd_sum_o
);

    logic [CNT_W-1:0]  cnt_q [NUM_SLOTS];
    logic [DATA_W-1:0] sum_q [NUM_SLOTS];

    // Decoded by comparison so out-of-range slot/pointer values read as empty.
    always_comb begin
        wr_ok_o  = 1'b0;
        rd_cnt_o = '0;
        rd_sum_o = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_slot_i == ADDR_W'(i)) begin
                wr_ok_o = (cnt_q[i] < CNT_W'(NUM_TERMS));
            end
            if (rd_ptr_i == ADDR_W'(i)) begin
                rd_cnt_o = cnt_q[i];
                rd_sum_o = sum_q[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cnt_q[i] <= '0;
                sum_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_slot_i == ADDR_W'(i) && cnt_q[i] < CNT_W'(NUM_TERMS)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                    sum_q[i] <= sum_q[i] + wr_data_i;
                end
            end
        end
    end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Collects partial sums into per-slot buckets and drains completed buckets
// strictly in slot order to memory over a valid/ready port.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned NUM_TERMS = DEF_NUM_TERMS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_slot,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_slot,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    localparam int unsigned CNT_W = cnt_width(NUM_TERMS);

    drain_state_e      state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              arm;
    logic              wr_en;
    logic              wr_ok;
    logic              drain;
    logic [CNT_W-1:0]  rd_cnt;
    logic [DATA_W-1:0] rd_sum;

    assign arm   = cfg_start && (state_q != StAccum);
    assign wr_en = in_valid && busy_q;
    assign drain = out_valid && out_ready;

    psum_slot_bank #(
        .NUM_SLOTS (NUM_SLOTS),
        .NUM_TERMS (NUM_TERMS),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W)
    ) u_bank (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (arm),
        .wr_en_i   (wr_en),
        .wr_slot_i (in_slot),
        .wr_data_i (in_data),
        .wr_ok_o   (wr_ok),
        .rd_ptr_i  (ptr_q),
        .rd_cnt_o  (rd_cnt),
        .rd_sum_o  (rd_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (cfg_start) begin
                        state_q <= StAccum;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                StAccum: begin
                    // Bad transfers are still consumed; only the flag records them.
                    if (wr_en && !wr_ok) begin
                        err_q <= 1'b1;
                    end
                    if (drain) begin
                        ptr_q <= ptr_q + ADDR_W'(1);
                        if (ptr_q == ADDR_W'(NUM_SLOTS - 1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign in_ready  = busy_q;
    assign out_valid = busy_q && (rd_cnt == CNT_W'(NUM_TERMS));
    assign out_slot  = ptr_q;
    assign out_data  = rd_sum;

endmodule
